// File: rtl/bypass_select_ctrl.sv
// Bypass select generator: matches consumer source tags against result-stage and WB-stage producers.
// Optional FP producer lanes and third operand are enabled by defining BYPASS_SELECT_FP_EN.
module bypass_select_ctrl #(
    parameter int INT_LANES  = 2,
    parameter int MEM_LANES  = 1,
    parameter int CPLX_LANES = 1,
`ifdef BYPASS_SELECT_FP_EN
    parameter int FP_LANES   = 1,
`endif
    parameter int CONS_LANES = 4,
    parameter int PREG_W     = 7,
    parameter int CNT_W      = 32,
    localparam int INT_LW    = (INT_LANES  > 1) ? $clog2(INT_LANES)  : 1,
    localparam int MEM_LW    = (MEM_LANES  > 1) ? $clog2(MEM_LANES)  : 1,
    localparam int CPLX_LW   = (CPLX_LANES > 1) ? $clog2(CPLX_LANES) : 1,
`ifdef BYPASS_SELECT_FP_EN
    localparam int FP_LW     = (FP_LANES   > 1) ? $clog2(FP_LANES)   : 1,
    localparam int P         = INT_LANES + MEM_LANES + CPLX_LANES + FP_LANES,
    localparam int SEL_W     = 4 + INT_LW + MEM_LW + CPLX_LW + FP_LW
`else
    localparam int P         = INT_LANES + MEM_LANES + CPLX_LANES,
    localparam int SEL_W     = 4 + INT_LW + MEM_LW + CPLX_LW
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [P-1:0]                 prod_valid,
    input  logic [P*PREG_W-1:0]          prod_tag,
    input  logic [CONS_LANES-1:0]        cons_valid,
    input  logic [CONS_LANES*PREG_W-1:0] cons_src_a,
    input  logic [CONS_LANES*PREG_W-1:0] cons_src_b,
    input  logic [CONS_LANES-1:0]        cons_src_a_wr,
    input  logic [CONS_LANES-1:0]        cons_src_b_wr,
`ifdef BYPASS_SELECT_FP_EN
    input  logic [CONS_LANES*PREG_W-1:0] cons_src_c,
    input  logic [CONS_LANES-1:0]        cons_src_c_wr,
    output logic [CONS_LANES*SEL_W-1:0]  sel_c,
`endif
    output logic [CONS_LANES*SEL_W-1:0]  sel_a,
    output logic [CONS_LANES*SEL_W-1:0]  sel_b,
    output logic [CNT_W-1:0]             hit_count
);

`ifdef BYPASS_SELECT_FP_EN
    localparam int NOPS = 3;
`else
    localparam int NOPS = 2;
`endif
    localparam int INC_W = $clog2(NOPS * CONS_LANES + 1);

    logic [CONS_LANES*PREG_W-1:0] src [NOPS];
    logic [CONS_LANES-1:0]        wr  [NOPS];

    logic [P-1:0]                 s0_v_q, s0_v_d;
    logic [P*PREG_W-1:0]          s0_tag_q, s0_tag_d;
    logic [CONS_LANES*SEL_W-1:0]  sel_q [NOPS];
    logic [CONS_LANES*SEL_W-1:0]  sel_d [NOPS];
    logic [CONS_LANES*SEL_W-1:0]  sel_n [NOPS];
    logic [CNT_W-1:0]             hit_q, hit_d;
    logic [INC_W-1:0]             inc;

    assign src[0] = cons_src_a;
    assign src[1] = cons_src_b;
    assign wr[0]  = cons_src_a_wr;
    assign wr[1]  = cons_src_b_wr;
    assign sel_a  = sel_q[0];
    assign sel_b  = sel_q[1];
`ifdef BYPASS_SELECT_FP_EN
    assign src[2] = cons_src_c;
    assign wr[2]  = cons_src_c_wr;
    assign sel_c  = sel_q[2];
`endif
    assign hit_count = hit_q;

    // First match wins: EX set (producers entering result stage) before WB set (S0), lanes in index order.
    function automatic logic [SEL_W-1:0] pick(
        input logic [P-1:0]        ex_v,
        input logic [P*PREG_W-1:0] ex_t,
        input logic [P-1:0]        wb_v,
        input logic [P*PREG_W-1:0] wb_t,
        input logic [PREG_W-1:0]   s,
        input logic                en
    );
        logic              hit, v;
        logic [PREG_W-1:0] t;
        logic [2:0]        stg;
        logic [INT_LW-1:0] li;
        logic [MEM_LW-1:0] lm;
        logic [CPLX_LW-1:0] lc;
`ifdef BYPASS_SELECT_FP_EN
        logic [FP_LW-1:0]  lf;
        lf = '0;
`endif
        hit = 1'b0;
        stg = '0;
        li  = '0;
        lm  = '0;
        lc  = '0;
        for (int set = 0; set < 2; set++) begin
            for (int p = 0; p < P; p++) begin
                v = (set == 0) ? ex_v[p] : wb_v[p];
                t = (set == 0) ? ex_t[p*PREG_W +: PREG_W] : wb_t[p*PREG_W +: PREG_W];
                if (en && !hit && v && (t == s)) begin
                    hit = 1'b1;
                    if (p < INT_LANES) begin
                        stg = 3'(set);
                        li  = INT_LW'(p);
                    end else if (p < INT_LANES + MEM_LANES) begin
                        stg = 3'(2 + set);
                        lm  = MEM_LW'(p - INT_LANES);
`ifdef BYPASS_SELECT_FP_EN
                    end else if (p < INT_LANES + MEM_LANES + CPLX_LANES) begin
                        stg = 3'(4 + set);
                        lc  = CPLX_LW'(p - INT_LANES - MEM_LANES);
                    end else begin
                        stg = 3'(6 + set);
                        lf  = FP_LW'(p - INT_LANES - MEM_LANES - CPLX_LANES);
                    end
`else
                    end else begin
                        stg = 3'(4 + set);
                        lc  = CPLX_LW'(p - INT_LANES - MEM_LANES);
                    end
`endif
                end
            end
        end
`ifdef BYPASS_SELECT_FP_EN
        return {hit, stg, li, lm, lc, lf};
`else
        return {hit, stg, li, lm, lc};
`endif
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [INC_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    always_comb begin
        sel_n = '{default: '0};
        inc   = '0;
        for (int o = 0; o < NOPS; o++) begin
            for (int c = 0; c < CONS_LANES; c++) begin
                sel_n[o][c*SEL_W +: SEL_W] = pick(prod_valid, prod_tag, s0_v_q, s0_tag_q,
                                                  src[o][c*PREG_W +: PREG_W], cons_valid[c] & wr[o][c]);
                inc = inc + INC_W'(sel_n[o][c*SEL_W + SEL_W - 1]);
            end
        end

        s0_v_d   = s0_v_q;
        s0_tag_d = s0_tag_q;
        sel_d    = sel_q;
        hit_d    = hit_q;
        if (flush) begin
            s0_v_d = '0;
            sel_d  = '{default: '0};
        end else if (!stall) begin
            s0_v_d   = prod_valid;
            s0_tag_d = prod_tag;
            sel_d    = sel_n;
            hit_d    = sat_add(hit_q, inc);
        end
    end

    // Only S0 feeds the WB candidate set; a WB-stage copy would have no reader.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_v_q <= '0;
            sel_q  <= '{default: '0};
            hit_q  <= '0;
        end else begin
            s0_v_q <= s0_v_d;
            sel_q  <= sel_d;
            hit_q  <= hit_d;
        end
        s0_tag_q <= s0_tag_d;
    end

endmodule

// File: tb/tb_bypass_select_ctrl.sv
// Testbench for bypass_select_ctrl: directed vector table, saturation sequence, randomized run against a candidate-queue model.
module tb_bypass_select_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [3:0]  prod_valid = '0;
    logic [27:0] prod_tag = '0;
    logic [3:0]  cons_valid = '0;
    logic [27:0] cons_src_a = '0, cons_src_b = '0;
    logic [3:0]  cons_src_a_wr = '0, cons_src_b_wr = '0;
    logic [27:0] sel_a, sel_b, s_sel_a, s_sel_b;
    logic [31:0] hit_count;
    logic [3:0]  s_hit_count;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bypass_select_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .prod_valid(prod_valid), .prod_tag(prod_tag), .cons_valid(cons_valid),
        .cons_src_a(cons_src_a), .cons_src_b(cons_src_b),
        .cons_src_a_wr(cons_src_a_wr), .cons_src_b_wr(cons_src_b_wr),
        .sel_a(sel_a), .sel_b(sel_b), .hit_count(hit_count)
    );

    bypass_select_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .prod_valid(prod_valid), .prod_tag(prod_tag), .cons_valid(cons_valid),
        .cons_src_a(cons_src_a), .cons_src_b(cons_src_b),
        .cons_src_a_wr(cons_src_a_wr), .cons_src_b_wr(cons_src_b_wr),
        .sel_a(s_sel_a), .sel_b(s_sel_b), .hit_count(s_hit_count)
    );

    // Select layout: {valid, stg[2:0], int_lane, mem_lane, cplx_lane}
    function automatic logic [6:0] enc(int v, int stg, int lane);
        logic [6:0] r;
        r = '0;
        if (v == 0) return r;
        r[6]   = 1'b1;
        r[5:3] = stg[2:0];
        case (stg / 2)
            0: r[2] = lane[0];
            1: r[1] = lane[0];
            default: r[0] = lane[0];
        endcase
        return r;
    endfunction

    typedef struct { int tag; int stg; int lane; } cand_t;

    logic [3:0] m_v;
    int         m_t [4];
    logic [6:0] m_sa [4];
    logic [6:0] m_sb [4];
    longint     m_hit;
    int         m_hit4;

    function automatic logic [6:0] find(input cand_t q[$], input int s, input bit en);
        if (!en) return '0;
        foreach (q[i]) if (q[i].tag == s) return enc(1, q[i].stg, q[i].lane);
        return '0;
    endfunction

    task automatic model_step();
        cand_t q[$];
        cand_t cd;
        bit v;
        int cls, cnt;
        logic [6:0] na [4];
        logic [6:0] nb [4];
        if (rst) begin
            m_v = '0;
            for (int c = 0; c < 4; c++) begin m_sa[c] = '0; m_sb[c] = '0; end
            m_hit = 0;
            m_hit4 = 0;
        end else if (flush) begin
            m_v = '0;
            for (int c = 0; c < 4; c++) begin m_sa[c] = '0; m_sb[c] = '0; end
        end else if (!stall) begin
            for (int set = 0; set < 2; set++) begin
                for (int p = 0; p < 4; p++) begin
                    v = (set == 0) ? prod_valid[p] : m_v[p];
                    cd.tag  = (set == 0) ? int'(prod_tag[p*7 +: 7]) : m_t[p];
                    cls     = (p < 2) ? 0 : (p == 2) ? 1 : 2;
                    cd.stg  = cls * 2 + set;
                    cd.lane = (p < 2) ? p : 0;
                    if (v) q.push_back(cd);
                end
            end
            cnt = 0;
            for (int c = 0; c < 4; c++) begin
                na[c] = find(q, int'(cons_src_a[c*7 +: 7]), cons_valid[c] && cons_src_a_wr[c]);
                nb[c] = find(q, int'(cons_src_b[c*7 +: 7]), cons_valid[c] && cons_src_b_wr[c]);
                cnt += int'(na[c][6]) + int'(nb[c][6]);
            end
            m_hit  = (m_hit + cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_hit + cnt;
            m_hit4 = (m_hit4 + cnt > 15) ? 15 : m_hit4 + cnt;
            m_v = prod_valid;
            for (int p = 0; p < 4; p++) m_t[p] = int'(prod_tag[p*7 +: 7]);
            for (int c = 0; c < 4; c++) begin m_sa[c] = na[c]; m_sb[c] = nb[c]; end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("model sel_a[%0d]", c), sel_a[c*7 +: 7], m_sa[c]);
            chk($sformatf("model sel_b[%0d]", c), sel_b[c*7 +: 7], m_sb[c]);
            chk($sformatf("model sat sel_a[%0d]", c), s_sel_a[c*7 +: 7], m_sa[c]);
            chk($sformatf("model sat sel_b[%0d]", c), s_sel_b[c*7 +: 7], m_sb[c]);
        end
        chk("model hit_count", hit_count, m_hit[31:0]);
        chk("model sat hit_count", s_hit_count, m_hit4[3:0]);
    endtask

    typedef struct {
        bit rst, stall, flush;
        logic [3:0] pv;
        int t0, t1, t2, t3;
        int cl;
        bit cv;
        int sa; bit wa;
        int sb; bit wb;
        logic [6:0] ea, eb;
        int eh;
    } vec_t;

    vec_t tbl[$];

    task automatic add(bit r, bit s, bit f, logic [3:0] pv, int t0, int t1, int t2, int t3,
                       int cl, bit cv, int sa, bit wa, int sb, bit wb,
                       logic [6:0] ea, logic [6:0] eb, int eh);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.pv = pv;
        v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3;
        v.cl = cl; v.cv = cv; v.sa = sa; v.wa = wa; v.sb = sb; v.wb = wb;
        v.ea = ea; v.eb = eb; v.eh = eh;
        tbl.push_back(v);
    endtask

    initial begin
        m_v = '0;
        m_hit = 0;
        m_hit4 = 0;
        for (int c = 0; c < 4; c++) begin m_sa[c] = '0; m_sb[c] = '0; m_t[c] = 0; end

        //  rst st fl pv      t0 t1 t2 t3  cl cv sa wa sb wb  exp_a          exp_b          hit
        add(1, 0, 0, 4'b0000, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 7'h00,         7'h00,         0);
        add(0, 0, 0, 4'b0001, 5, 0, 0, 0,  0, 1, 5, 1, 0, 0, enc(1, 0, 0),  7'h00,         1);
        add(0, 0, 0, 4'b0100, 0, 0, 9, 0,  1, 0, 0, 0, 0, 0, 7'h00,         7'h00,         1);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0,  1, 1, 5, 1, 9, 1, 7'h00,         enc(1, 3, 0),  2);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0,  1, 1, 0, 0, 9, 1, 7'h00,         7'h00,         2);
        add(0, 0, 0, 4'b0010, 0, 12, 0, 0, 2, 0, 0, 0, 0, 0, 7'h00,         7'h00,         2);
        add(0, 0, 0, 4'b1000, 0, 0, 0, 12, 2, 1, 12, 1, 0, 0, enc(1, 4, 0), 7'h00,         3);
        add(0, 0, 0, 4'b0001, 0, 0, 0, 0,  3, 1, 0, 0, 0, 0, 7'h00,         7'h00,         3);
        add(0, 0, 0, 4'b0001, 3, 0, 0, 0,  0, 1, 3, 1, 0, 0, enc(1, 0, 0),  7'h00,         4);
        add(0, 1, 0, 4'b0001, 50, 0, 0, 0, 0, 1, 3, 1, 0, 0, enc(1, 0, 0),  7'h00,         4);
        add(0, 1, 0, 4'b0001, 50, 0, 0, 0, 0, 1, 3, 1, 0, 0, enc(1, 0, 0),  7'h00,         4);
        add(0, 1, 0, 4'b0001, 50, 0, 0, 0, 0, 1, 3, 1, 0, 0, enc(1, 0, 0),  7'h00,         4);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0,  0, 1, 3, 1, 0, 0, enc(1, 1, 0),  7'h00,         5);
        add(0, 0, 0, 4'b0001, 7, 0, 0, 0,  0, 0, 0, 0, 0, 0, 7'h00,         7'h00,         5);
        add(0, 0, 1, 4'b0001, 7, 0, 0, 0,  0, 1, 7, 1, 0, 0, 7'h00,         7'h00,         5);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0,  0, 1, 7, 1, 0, 0, 7'h00,         7'h00,         5);
        add(0, 0, 0, 4'b0001, 20, 0, 0, 0, 0, 1, 20, 1, 0, 0, enc(1, 0, 0), 7'h00,         6);
        add(0, 1, 1, 4'b0000, 0, 0, 0, 0,  0, 1, 20, 1, 0, 0, 7'h00,        7'h00,         6);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0,  0, 1, 20, 1, 0, 0, 7'h00,        7'h00,         6);
        add(0, 0, 0, 4'b0011, 30, 30, 0, 0, 1, 1, 30, 1, 30, 1, enc(1, 0, 0), enc(1, 0, 0), 8);
        add(1, 0, 0, 4'b0001, 40, 0, 0, 0, 0, 1, 30, 1, 0, 0, 7'h00,        7'h00,         0);
        add(0, 0, 0, 4'b0000, 0, 0, 0, 0,  0, 1, 40, 1, 0, 0, 7'h00,        7'h00,         0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; stall = tbl[i].stall; flush = tbl[i].flush;
            prod_valid = tbl[i].pv;
            prod_tag = {7'(tbl[i].t3), 7'(tbl[i].t2), 7'(tbl[i].t1), 7'(tbl[i].t0)};
            cons_valid = '0; cons_src_a = '0; cons_src_b = '0;
            cons_src_a_wr = '0; cons_src_b_wr = '0;
            cons_valid[tbl[i].cl] = tbl[i].cv;
            cons_src_a[tbl[i].cl*7 +: 7] = 7'(tbl[i].sa);
            cons_src_b[tbl[i].cl*7 +: 7] = 7'(tbl[i].sb);
            cons_src_a_wr[tbl[i].cl] = tbl[i].wa;
            cons_src_b_wr[tbl[i].cl] = tbl[i].wb;
            cycle();
            chk($sformatf("vec%0d sel_a", i), sel_a[tbl[i].cl*7 +: 7], tbl[i].ea);
            chk($sformatf("vec%0d sel_b", i), sel_b[tbl[i].cl*7 +: 7], tbl[i].eb);
            chk($sformatf("vec%0d hit_count", i), hit_count, 64'(tbl[i].eh));
        end

        // Saturation: eight hits per cycle into a 4-bit counter must stick at 15.
        rst = 1'b1; stall = 1'b0; flush = 1'b0; prod_valid = '0; cons_valid = '0;
        cycle();
        rst = 1'b0;
        prod_valid = 4'b0001; prod_tag = {7'd0, 7'd0, 7'd0, 7'd1};
        cons_valid = 4'hF;
        cons_src_a = {4{7'd1}}; cons_src_b = {4{7'd1}};
        cons_src_a_wr = 4'hF; cons_src_b_wr = 4'hF;
        cycle();
        chk("sat step1 narrow", s_hit_count, 64'd8);
        chk("sat step1 wide", hit_count, 64'd8);
        chk("sat step1 sel_a[3]", sel_a[21 +: 7], enc(1, 0, 0));
        cycle();
        chk("sat step2 narrow", s_hit_count, 64'd15);
        chk("sat step2 wide", hit_count, 64'd16);
        cycle();
        chk("sat step3 narrow", s_hit_count, 64'd15);
        chk("sat step3 wide", hit_count, 64'd24);

        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom % 100) == 0;
            stall = ($urandom % 10) == 0;
            flush = ($urandom % 20) == 0;
            prod_valid = 4'($urandom);
            for (int p = 0; p < 4; p++) prod_tag[p*7 +: 7] = 7'($urandom % 8);
            cons_valid = 4'($urandom);
            for (int c = 0; c < 4; c++) begin
                cons_src_a[c*7 +: 7] = 7'($urandom % 8);
                cons_src_b[c*7 +: 7] = 7'($urandom % 8);
                cons_src_a_wr[c] = ($urandom % 5) != 0;
                cons_src_b_wr[c] = ($urandom % 5) != 0;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
